// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, index type and helpers for the register file
package rf_pkg;
    localparam int XLEN_D   = 32;
    localparam int NREGS_D  = 32;
    localparam int ZERO_REG = 0;
    localparam int MAX_REGS = 256;

    typedef logic [$clog2(NREGS_D)-1:0] reg_idx_t;

    function automatic int popcount(input logic [MAX_REGS-1:0] v);
        int n = 0;
        for (int i = 0; i < MAX_REGS; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/rf_pending_tracker.sv
// rf_pending_tracker: per-register pending bits with occupancy counter and flush
module rf_pending_tracker
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_D,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      pend_cnt,
    output logic             sb_full
);
    logic set, clr, inc, dec;
    logic [NREGS-1:0] set_m, clr_m;

    // decode set/clear masks; a same-address reserve cancels the clear's decrement
    always_comb begin
        set   = rsv_en && rsv_addr != AW'(ZERO_REG);
        clr   = we && wr_addr != AW'(ZERO_REG);
        set_m = set ? NREGS'(1) << rsv_addr : '0;
        clr_m = clr ? NREGS'(1) << wr_addr : '0;
        inc   = set && !pending[rsv_addr];
        dec   = clr && pending[wr_addr] && !(set && rsv_addr == wr_addr);
    end

    // flush beats reserve and clear; otherwise the new producer wins over writeback
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else if (flush) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= (pending & ~clr_m) | set_m;
            pend_cnt <= pend_cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end

    assign sb_full = pend_cnt == (AW+1)'(NREGS - 1);

    cnt_matches_bits: assert property (@(posedge clk) disable iff (!rst)
        32'(pend_cnt) == popcount(MAX_REGS'(pending)));
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read register file with write bypass, zero reg and RAW scoreboard
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int NREAD = 2,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREAD-1:0][AW-1:0]   rd_addr,
    output logic [NREAD-1:0][XLEN-1:0] rd_data,
    output logic [NREAD-1:0]           rd_pending,
    input  logic                       we,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    input  logic                       flush,
    output logic [AW:0]                pend_cnt,
    output logic                       sb_full
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;

    // data array; register 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int j = 0; j < NREGS; j++) regs[j] <= '0;
        end else if (we && wr_addr != AW'(ZERO_REG)) begin
            regs[wr_addr] <= wr_data;
        end

    rf_pending_tracker #(.NREGS(NREGS)) u_trk (
        .clk(clk),
        .rst(rst),
        .we(we),
        .wr_addr(wr_addr),
        .rsv_en(rsv_en),
        .rsv_addr(rsv_addr),
        .flush(flush),
        .pending(pending),
        .pend_cnt(pend_cnt),
        .sb_full(sb_full)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic zero, hit;
        assign zero          = rd_addr[i] == AW'(ZERO_REG);
        assign hit           = we && wr_addr == rd_addr[i];
        assign rd_data[i]    = zero ? '0 : hit ? wr_data : regs[rd_addr[i]];
        assign rd_pending[i] = !zero && !hit && pending[rd_addr[i]];
    end
endmodule
